// File: rtl/uart_pixel_cmd_ctrl.sv
// Frames UART byte strobes into pixel-write commands for the framebuffer write port.
// Define PIXCMD_CHECKSUM_EN for the 7-byte packet with a trailing XOR checksum byte.
module uart_pixel_cmd_ctrl #(
    parameter logic [7:0] SYNC_BYTE    = 8'hA5,
    parameter int         H_ACTIVE     = 640,
    parameter int         V_ACTIVE     = 480,
    parameter int         TIMEOUT_CLKS = 8680
) (
    input  logic       i_Clock,
    input  logic       i_Rst_n,
    input  logic       i_RX_DV,
    input  logic [7:0] i_RX_Byte,
    output logic       o_Wr_Valid,
    input  logic       i_Wr_Ready,
    output logic [9:0] o_Wr_X,
    output logic [9:0] o_Wr_Y,
    output logic [7:0] o_Wr_Color,
    output logic       o_Busy,
    output logic       o_Err,
    output logic [1:0] o_Err_Code
);

    typedef enum logic [2:0] {IDLE, XH, XL, YH, YL, COLOR, CHK, WRITE} state_t;
    typedef enum logic [1:0] {
        ERR_OVERRUN  = 2'b00,
        ERR_TIMEOUT  = 2'b01,
        ERR_CHECKSUM = 2'b10,
        ERR_RANGE    = 2'b11
    } err_t;

    localparam logic [13:0] TIMEOUT_LAST = 14'(TIMEOUT_CLKS - 1);
    localparam logic [9:0]  H_LIMIT      = 10'(H_ACTIVE);
    localparam logic [9:0]  V_LIMIT      = 10'(V_ACTIVE);

    state_t      state;
    logic [13:0] to_cnt;
    logic [1:0]  xh_lo, yh_lo;
    logic [7:0]  xl, yl;
    logic [9:0]  x_val, y_val;
    logic [7:0]  final_color;
    logic        final_byte, chk_ok, range_ok;

    assign x_val    = {xh_lo, xl};
    assign y_val    = {yh_lo, yl};
    assign range_ok = (x_val < H_LIMIT) && (y_val < V_LIMIT);

`ifdef PIXCMD_CHECKSUM_EN
    logic [7:0] color, csum;
    assign final_byte  = (state == CHK);
    assign final_color = color;
    assign chk_ok      = (i_RX_Byte == csum);
`else
    // Without a checksum byte the colour byte closes the packet and is written straight through.
    assign final_byte  = (state == COLOR);
    assign final_color = i_RX_Byte;
    assign chk_ok      = 1'b1;
`endif

    always_ff @(posedge i_Clock or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state      <= IDLE;
            to_cnt     <= '0;
            xh_lo      <= '0;
            xl         <= '0;
            yh_lo      <= '0;
            yl         <= '0;
`ifdef PIXCMD_CHECKSUM_EN
            color      <= '0;
            csum       <= '0;
`endif
            o_Wr_Valid <= 1'b0;
            o_Wr_X     <= '0;
            o_Wr_Y     <= '0;
            o_Wr_Color <= '0;
            o_Busy     <= 1'b0;
            o_Err      <= 1'b0;
            o_Err_Code <= '0;
        end else begin
            // NOTE: o_Err defaults low every cycle so any error assignment below is a single-cycle pulse.
            o_Err <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_RX_DV && i_RX_Byte == SYNC_BYTE) begin
                        state  <= XH;
                        o_Busy <= 1'b1;
                        to_cnt <= '0;
`ifdef PIXCMD_CHECKSUM_EN
                        csum   <= '0;
`endif
                    end
                end
                WRITE: begin
                    if (i_RX_DV) begin
                        o_Err      <= 1'b1;
                        o_Err_Code <= ERR_OVERRUN;
                    end
                    if (i_Wr_Ready) begin
                        o_Wr_Valid <= 1'b0;
                        o_Busy     <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: begin
                    if (i_RX_DV) begin
                        to_cnt <= '0;
`ifdef PIXCMD_CHECKSUM_EN
                        csum   <= csum ^ i_RX_Byte;
`endif
                        case (state)
                            XH: begin xh_lo <= i_RX_Byte[1:0]; state <= XL; end
                            XL: begin xl    <= i_RX_Byte;      state <= YH; end
                            YH: begin yh_lo <= i_RX_Byte[1:0]; state <= YL; end
                            YL: begin yl    <= i_RX_Byte;      state <= COLOR; end
`ifdef PIXCMD_CHECKSUM_EN
                            COLOR: begin color <= i_RX_Byte;   state <= CHK; end
`endif
                            default: ;
                        endcase
                        if (final_byte) begin
                            if (!chk_ok) begin
                                state      <= IDLE;
                                o_Busy     <= 1'b0;
                                o_Err      <= 1'b1;
                                o_Err_Code <= ERR_CHECKSUM;
                            end else if (!range_ok) begin
                                state      <= IDLE;
                                o_Busy     <= 1'b0;
                                o_Err      <= 1'b1;
                                o_Err_Code <= ERR_RANGE;
                            end else begin
                                state      <= WRITE;
                                o_Wr_Valid <= 1'b1;
                                o_Wr_X     <= x_val;
                                o_Wr_Y     <= y_val;
                                o_Wr_Color <= final_color;
                            end
                        end
                    end else if (to_cnt == TIMEOUT_LAST) begin
                        state      <= IDLE;
                        o_Busy     <= 1'b0;
                        o_Err      <= 1'b1;
                        o_Err_Code <= ERR_TIMEOUT;
                    end else begin
                        to_cnt <= to_cnt + 14'd1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_pixel_cmd_ctrl.sv
// Self-checking bench: packet-level reference model compared every cycle, plus directed literal checks.
// Honours PIXCMD_CHECKSUM_EN to select the 6- or 7-byte packet format.
module tb_uart_pixel_cmd_ctrl;

    localparam int TIMEOUT_CLKS = 8680;
`ifdef PIXCMD_CHECKSUM_EN
    localparam int PKT_LEN = 7;
`else
    localparam int PKT_LEN = 6;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       dv = 1'b0;
    logic [7:0] rx_byte = 8'h00;
    logic       ready = 1'b0;
    logic       wr_valid, busy, err;
    logic [9:0] wr_x, wr_y;
    logic [7:0] wr_color;
    logic [1:0] err_code;

    uart_pixel_cmd_ctrl dut (
        .i_Clock    (clk),
        .i_Rst_n    (rst_n),
        .i_RX_DV    (dv),
        .i_RX_Byte  (rx_byte),
        .o_Wr_Valid (wr_valid),
        .i_Wr_Ready (ready),
        .o_Wr_X     (wr_x),
        .o_Wr_Y     (wr_y),
        .o_Wr_Color (wr_color),
        .o_Busy     (busy),
        .o_Err      (err),
        .o_Err_Code (err_code)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: bytes of the packet under assembly, idle edges since its last byte, pending write.
    logic [7:0] m_pkt[$];
    int         m_gap = 0;
    bit         m_wr = 1'b0;
    logic [9:0] m_x = '0, m_y = '0;
    logic [7:0] m_c = '0;
    bit         m_err = 1'b0;
    logic [1:0] m_code = '0;
    int         m_writes = 0;

    int         dut_xfers = 0;
    int         dut_errs = 0;
    logic [1:0] dut_last_code = '0;
    bit         rand_ready = 1'b0;
    bit         rand_gaps = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pkt.delete();
        m_gap  = 0;
        m_wr   = 1'b0;
        m_err  = 1'b0;
        m_code = '0;
    endtask

    task automatic finish_packet();
        logic [7:0] b1, b2, b3, b4, b5;
        logic [9:0] x, y;
        bit         sum_ok;
        b1 = m_pkt[1]; b2 = m_pkt[2]; b3 = m_pkt[3]; b4 = m_pkt[4]; b5 = m_pkt[5];
        x = {b1[1:0], b2};
        y = {b3[1:0], b4};
        sum_ok = 1'b1;
`ifdef PIXCMD_CHECKSUM_EN
        sum_ok = (m_pkt[6] == (b1 ^ b2 ^ b3 ^ b4 ^ b5));
`endif
        if (!sum_ok) begin
            m_err = 1'b1; m_code = 2'b10;
        end else if (x >= 10'd640 || y >= 10'd480) begin
            m_err = 1'b1; m_code = 2'b11;
        end else begin
            m_wr = 1'b1; m_x = x; m_y = y; m_c = b5;
        end
        m_pkt.delete();
    endtask

    task automatic model_step(input logic d, input logic [7:0] b, input logic r);
        m_err = 1'b0;
        if (m_wr) begin
            if (d) begin m_err = 1'b1; m_code = 2'b00; end
            if (r) begin m_wr = 1'b0; m_writes++; end
        end else if (m_pkt.size() == 0) begin
            if (d && b == 8'hA5) begin m_pkt.push_back(b); m_gap = 0; end
        end else if (d) begin
            m_pkt.push_back(b);
            m_gap = 0;
            if (m_pkt.size() == PKT_LEN) finish_packet();
        end else begin
            m_gap++;
            if (m_gap == TIMEOUT_CLKS) begin
                m_err = 1'b1; m_code = 2'b01;
                m_pkt.delete();
            end
        end
    endtask

    // Compare process: advance the model on each rising edge, check the DUT on the falling edge.
    initial begin
        forever begin
            @(posedge clk);
            if (!rst_n) model_reset();
            else model_step(dv, rx_byte, ready);
            @(negedge clk);
            if (!rst_n) model_reset();
            check("valid", wr_valid, m_wr);
            if (m_wr) begin
                check("wr_x", wr_x, m_x);
                check("wr_y", wr_y, m_y);
                check("wr_color", wr_color, m_c);
            end
            check("busy", busy, m_wr || (m_pkt.size() > 0));
            check("err", err, m_err);
            check("err_code", err_code, m_code);
            if (err) begin dut_errs++; dut_last_code = err_code; end
            if (wr_valid && ready) dut_xfers++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_ready) ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic send(input logic [7:0] b);
        dv = 1'b1;
        rx_byte = b;
        tick();
        dv = 1'b0;
    endtask

    task automatic send_gap(input logic [7:0] b);
        send(b);
        if (rand_gaps) idle($urandom_range(0, 2));
    endtask

    task automatic send_pkt(input logic [7:0] xh, xl, yh, yl, c, input bit corrupt, input int gap1);
        send_gap(8'hA5);
        idle(gap1);
        send_gap(xh);
        send_gap(xl);
        send_gap(yh);
        send_gap(yl);
`ifdef PIXCMD_CHECKSUM_EN
        send_gap(c);
        send(xh ^ xl ^ yh ^ yl ^ c ^ {7'd0, corrupt});
`else
        send(c);
`endif
    endtask

    int e0, t0;
    logic [9:0] xv, yv;

    initial begin
        idle(3);
        check("rst_valid", wr_valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_err", err, 1'b0);
        check("rst_code", err_code, 2'b00);
        rst_n = 1'b1;
        tick();

        // Good packet, ready already high: valid at n+1, transfer, idle at n+2.
        ready = 1'b1;
        e0 = dut_errs; t0 = dut_xfers;
        send_pkt(8'h01, 8'h3F, 8'h00, 8'hF0, 8'h1C, 1'b0, 0);
        check("tp_valid_n1", wr_valid, 1'b1);
        check("tp_x", wr_x, 10'd319);
        check("tp_y", wr_y, 10'd240);
        check("tp_color", wr_color, 8'h1C);
        tick();
        check("tp_valid_n2", wr_valid, 1'b0);
        check("tp_busy_n2", busy, 1'b0);
        check("tp_xfers", dut_xfers - t0, 1);
        check("tp_no_err", dut_errs - e0, 0);

`ifdef PIXCMD_CHECKSUM_EN
        e0 = dut_errs;
        send_pkt(8'h01, 8'h3F, 8'h00, 8'hF0, 8'h1C, 1'b1, 0);
        check("chk_err", err, 1'b1);
        check("chk_code", err_code, 2'b10);
        check("chk_busy", busy, 1'b0);
        check("chk_valid", wr_valid, 1'b0);
        tick();
        check("chk_err_single", err, 1'b0);
`endif

        // Range boundaries on both axes.
        send_pkt(8'h02, 8'h80, 8'h00, 8'h10, 8'h55, 1'b0, 0);
        check("x640_err", err, 1'b1);
        check("x640_code", err_code, 2'b11);
        tick();
        send_pkt(8'hFE, 8'h7F, 8'h00, 8'h10, 8'h55, 1'b0, 0);
        check("x639_valid", wr_valid, 1'b1);
        check("x639_x", wr_x, 10'd639);
        tick();
        send_pkt(8'h00, 8'h05, 8'h01, 8'hE0, 8'h66, 1'b0, 0);
        check("y480_code", err_code, 2'b11);
        tick();
        send_pkt(8'h00, 8'h05, 8'h01, 8'hDF, 8'h66, 1'b0, 0);
        check("y479_y", wr_y, 10'd479);
        tick();

        // Timeout after A5 01 and silence; then a full packet; then a DV exactly on the expiry cycle.
        send(8'hA5);
        send(8'h01);
        idle(TIMEOUT_CLKS - 1);
        check("to_not_yet", err, 1'b0);
        check("to_busy_before", busy, 1'b1);
        tick();
        check("to_err", err, 1'b1);
        check("to_code", err_code, 2'b01);
        check("to_busy", busy, 1'b0);
        t0 = dut_xfers;
        send_pkt(8'h00, 8'h64, 8'h00, 8'h32, 8'hE3, 1'b0, 0);
        check("to_next_x", wr_x, 10'd100);
        tick();
        e0 = dut_errs;
        send_pkt(8'h01, 8'h3F, 8'h00, 8'hF0, 8'h1C, 1'b0, TIMEOUT_CLKS - 1);
        check("expiry_dv_valid", wr_valid, 1'b1);
        tick();
        check("expiry_dv_no_err", dut_errs - e0, 0);
        check("to_xfers", dut_xfers - t0, 2);

        // Ready held low: two overruns while waiting, one transfer when ready rises.
        ready = 1'b0;
        send_pkt(8'h01, 8'h3F, 8'h00, 8'hF0, 8'h1C, 1'b0, 0);
        e0 = dut_errs; t0 = dut_xfers;
        idle(20);
        send(8'h33);
        idle(30);
        send(8'hA5);
        idle(47);
        check("ovr_count", dut_errs - e0, 2);
        check("ovr_code", dut_last_code, 2'b00);
        check("ovr_valid_held", wr_valid, 1'b1);
        check("ovr_x_held", wr_x, 10'd319);
        ready = 1'b1;
        tick();
        check("ovr_single_xfer", dut_xfers - t0, 1);
        check("ovr_valid_drop", wr_valid, 1'b0);

        // Leave a nonzero error code, then reset during a pending write.
        send_pkt(8'h02, 8'h80, 8'h00, 8'h10, 8'h55, 1'b0, 0);
        tick();
        ready = 1'b0;
        send_pkt(8'h01, 8'h3F, 8'h00, 8'hF0, 8'h1C, 1'b0, 0);
        idle(3);
        e0 = dut_errs;
        #1 rst_n = 1'b0;
        #1;
        check("rw_valid", wr_valid, 1'b0);
        check("rw_busy", busy, 1'b0);
        check("rw_code", err_code, 2'b00);
        check("rw_x", wr_x, 10'd0);
        check("rw_color", wr_color, 8'd0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        send(8'h00);
        send(8'hFF);
        idle(3);
        check("junk_no_err", dut_errs - e0, 0);
        check("junk_idle", busy, 1'b0);

        // Randomized traffic: ready toggling, byte gaps, corrupt/out-of-range packets, stray bytes.
        rand_ready = 1'b1;
        rand_gaps = 1'b1;
        for (int i = 0; i < 300; i++) begin
            xv = 10'($urandom_range(0, 700));
            yv = 10'($urandom_range(0, 520));
            send_pkt({6'($urandom), xv[9:8]}, xv[7:0], {6'($urandom), yv[9:8]}, yv[7:0],
                     8'($urandom), ($urandom_range(0, 9) == 0), $urandom_range(0, 2));
            repeat ($urandom_range(0, 4)) begin
                if ($urandom_range(0, 2) == 0) send(8'($urandom));
                else tick();
            end
        end
        rand_ready = 1'b0;
        ready = 1'b1;
        idle(TIMEOUT_CLKS + 5);
        check("total_writes", dut_xfers, m_writes);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
